retire_commit_unit: RTL

- Retire stage directly downstream of the reorder buffer. Each cycle it consumes up to two in-order ROB head entries.
- For each accepted entry it frees the stale physical register to the free list and emits a commit trace.
- Committed stores go into a small store buffer, which drains to data memory through a req/ack handshake.
- It back-pressures the ROB when the store buffer lacks space.

---
 rtl/retire_commit_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/retire_commit_unit.sv
// Retire/commit stage sitting behind the reorder buffer.
// Retires up to two in-order ROB head entries per cycle, releases stale
// physical registers, emits a commit trace and funnels committed stores
// through a small circular store buffer that drains over a req/ack port.
module retire_commit_unit #(
  parameter int PREG_W   = 6,
  parameter int DATA_W   = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid1,
  input  logic                          in_valid2,
  input  logic [DATA_W-1:0]             in_pc1,
  input  logic [DATA_W-1:0]             in_pc2,
  input  logic [PREG_W-1:0]             in_rd_old1,
  input  logic [PREG_W-1:0]             in_rd_old2,
  input  logic                          in_regwrite1,
  input  logic                          in_regwrite2,
  input  logic                          in_memwrite1,
  input  logic                          in_memwrite2,
  input  logic [DATA_W-1:0]             in_addr1,
  input  logic [DATA_W-1:0]             in_addr2,
  input  logic [DATA_W-1:0]             in_stdata1,
  input  logic [DATA_W-1:0]             in_stdata2,
  output logic                          accept1,
  output logic                          accept2,
  output logic                          free_valid1,
  output logic                          free_valid2,
  output logic [PREG_W-1:0]             free_reg1,
  output logic [PREG_W-1:0]             free_reg2,
  output logic                          commit_valid1,
  output logic                          commit_valid2,
  output logic [DATA_W-1:0]             commit_pc1,
  output logic [DATA_W-1:0]             commit_pc2,
  output logic                          mem_req,
  output logic [DATA_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_ack,
  output logic [$clog2(SB_DEPTH):0]     sb_count,
  output logic [31:0]                   retired_count
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } drainState_e;

  drainState_e       drainState_q, drainState_d;

  logic [CW-1:0]     sbCount_q, sbCount_d;
  logic [PW-1:0]     rdPtr_q;
  logic [PW-1:0]     wrPtr_q;
  logic [DATA_W-1:0] sbAddr_q [SB_DEPTH];
  logic [DATA_W-1:0] sbData_q [SB_DEPTH];

  logic [CW-1:0]     space;
  logic [CW-1:0]     storeSum;
  logic              push1;
  logic              push2;
  logic              sbPop;

  logic              freeValid1_q, freeValid2_q;
  logic [PREG_W-1:0] freeReg1_q, freeReg2_q;
  logic              commitValid1_q, commitValid2_q;
  logic [DATA_W-1:0] commitPc1_q, commitPc2_q;
  logic [31:0]       retiredCount_q;
  logic [DATA_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;

  // Acceptance looks only at the registered occupancy; a pop happening this
  // cycle does not free room early. Nothing retires while reset is held.
  always_comb begin
    space    = CW'(SB_DEPTH) - sbCount_q;
    storeSum = CW'(in_memwrite1) + CW'(in_memwrite2);
    accept1  = reset & in_valid1 & (~in_memwrite1 | (space >= CW'(1)));
    accept2  = accept1 & in_valid2 & (storeSum <= space);
    push1    = accept1 & in_memwrite1;
    push2    = accept2 & in_memwrite2;
  end

  // Commit trace, free-list release and retirement counter, one cycle after accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freeValid1_q   <= 1'b0;
      freeValid2_q   <= 1'b0;
      freeReg1_q     <= '0;
      freeReg2_q     <= '0;
      commitValid1_q <= 1'b0;
      commitValid2_q <= 1'b0;
      commitPc1_q    <= '0;
      commitPc2_q    <= '0;
      retiredCount_q <= '0;
    end else begin
      commitValid1_q <= accept1;
      commitValid2_q <= accept2;
      commitPc1_q    <= accept1 ? in_pc1 : '0;
      commitPc2_q    <= accept2 ? in_pc2 : '0;
      freeValid1_q   <= accept1 & in_regwrite1 & (in_rd_old1 != '0);
      freeValid2_q   <= accept2 & in_regwrite2 & (in_rd_old2 != '0);
      freeReg1_q     <= (accept1 & in_regwrite1) ? in_rd_old1 : '0;
      freeReg2_q     <= (accept2 & in_regwrite2) ? in_rd_old2 : '0;
      retiredCount_q <= retiredCount_q + 32'(accept1) + 32'(accept2);
    end
  end

  // Occupancy bookkeeping: up to two pushes and one pop per cycle.
  always_comb begin
    sbCount_d = sbCount_q + CW'(push1) + CW'(push2) - CW'(sbPop);
  end

  // Circular store buffer; slot1 lands before slot2 when both push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sbCount_q <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sbAddr_q[i] <= '0;
        sbData_q[i] <= '0;
      end
    end else begin
      sbCount_q <= sbCount_d;
      if (push1) begin
        sbAddr_q[wrPtr_q] <= in_addr1;
        sbData_q[wrPtr_q] <= in_stdata1;
      end
      if (push2) begin
        sbAddr_q[wrPtr_q + PW'(push1)] <= in_addr2;
        sbData_q[wrPtr_q + PW'(push1)] <= in_stdata2;
      end
      wrPtr_q <= wrPtr_q + PW'(push1) + PW'(push2);
      if (sbPop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
    end
  end

  // Drain FSM next-state: IDLE latches the head into the request registers,
  // REQ holds them until the memory acknowledges, then pops and clears.
  always_comb begin
    drainState_d = drainState_q;
    sbPop        = 1'b0;
    memAddr_d    = memAddr_q;
    memWdata_d   = memWdata_q;
    case (drainState_q)
      S_IDLE: begin
        if (sbCount_q != '0) begin
          drainState_d = S_REQ;
          memAddr_d    = sbAddr_q[rdPtr_q];
          memWdata_d   = sbData_q[rdPtr_q];
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          sbPop        = 1'b1;
          drainState_d = S_IDLE;
          memAddr_d    = '0;
          memWdata_d   = '0;
        end
      end
      default: begin
        drainState_d = S_IDLE;
        memAddr_d    = '0;
        memWdata_d   = '0;
      end
    endcase
  end

  // Drain FSM state and request payload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drainState_q <= S_IDLE;
      memAddr_q    <= '0;
      memWdata_q   <= '0;
    end else begin
      drainState_q <= drainState_d;
      memAddr_q    <= memAddr_d;
      memWdata_q   <= memWdata_d;
    end
  end

  assign free_valid1   = freeValid1_q;
  assign free_valid2   = freeValid2_q;
  assign free_reg1     = freeReg1_q;
  assign free_reg2     = freeReg2_q;
  assign commit_valid1 = commitValid1_q;
  assign commit_valid2 = commitValid2_q;
  assign commit_pc1    = commitPc1_q;
  assign commit_pc2    = commitPc2_q;
  assign mem_req       = (drainState_q == S_REQ);
  assign mem_addr      = memAddr_q;
  assign mem_wdata     = memWdata_q;
  assign sb_count      = sbCount_q;
  assign retired_count = retiredCount_q;

endmodule
